interrupt_sequencer: RTL
========================

// Module: interrupt_sequencer
// PURPOSE
//  Interrupt scheduler for the 6502 core. Arbitrates RESET, NMI and IRQ and drives int_flag
//  into the instruction controller, which then loads BRK (0x00) at the next T1.
//  Tracks the injected BRK sequence and supplies the vector address, B bit and stack-write
//  suppression to the datapath. Handles NMI hijack of BRK/IRQ.
// PARAMETERS
//  VEC_NMI    16'hFFFA  NMI vector address
//  VEC_RESET  16'hFFFC  RESET vector address
//  VEC_IRQ    16'hFFFE  IRQ/BRK vector address
// PORTS
//  sys_clock       in   1   main system clock; the only clock
//  rst             in   1   synchronous, active-high reset
//  clk_ph1         in   1   CPU phase-1 enable; all state advances only on sys_clock edges with clk_ph1=1
//  nmi_n           in   1   NMI line, active low, edge-triggered (synchronous to sys_clock)
//  irq_n           in   1   IRQ line, active low, level-sensitive
//  i_flag          in   1   status-register I bit (1 = IRQ masked)
//  next_cycle      in   3   next instruction cycle from the instruction controller
//  IR              in   8   current instruction register
//  vector_fetch    in   1   datapath is reading the vector low byte this cycle
//  int_flag        out  1   registered; 1 = next T1 loads BRK instead of the fetched opcode
//  int_active      out  1   1 while an injected (hardware) BRK sequence runs
//  b_flag          out  1   B bit value for the status push (1 = software BRK)
//  suppress_write  out  1   1 during the RESET sequence; stack writes become reads
//  vector_addr     out  16  vector address for the current BRK sequence
//  nmi_pending     out  1   latched NMI edge not yet serviced
// BEHAVIOUR
//  Reset (rst=1 at a sys_clock edge, clk_ph1 ignored): state=IDLE, rst_pend=1, nmi_pend=0,
//   nmi_prev=1, int_flag=0, int_active=0, b_flag=0, suppress_write=0, vector_addr=VEC_RESET.
//   Reset mid-sequence aborts the sequence immediately with the same values.
//  Edge detect, on each ph1: nmi_prev<=nmi_n. If nmi_prev=1 and nmi_n=0, nmi_pend<=1.
//   A line held low never retriggers. When set and clear coincide, set wins.
//  irq_req = ~irq_n & ~i_flag. This is level-sensitive and is not latched.
//  Poll, on each ph1: int_flag <= (state==IDLE) & (rst_pend | nmi_pend | irq_req).
//   The instruction controller samples int_flag on the ph1 where next_cycle==1.
//   int_flag is forced to 0 in SERVICE and on the first ph1 after SERVICE exits.
//   The instruction after an interrupt therefore always executes.
//  FSM states: IDLE, SERVICE, SWBRK.
//   IDLE -> SERVICE: ph1 & next_cycle==1 & int_flag. Source is captured by priority
//    RESET > NMI > IRQ. Sets int_active=1 and b_flag=0. suppress_write=1 only if the source
//    is RESET. vector_addr is set from the source.
//   IDLE -> SWBRK: ph1 & next_cycle==2 & IR==8'h00 & ~int_active. Sets b_flag=1 and
//    vector_addr=VEC_IRQ.
//   SERVICE/SWBRK -> IDLE: ph1 & next_cycle==1 (the next opcode fetch). Clears int_active,
//    suppress_write and b_flag.
//  At vector_fetch & ph1:
//   - Source RESET: clear rst_pend.
//   - Source NMI: clear nmi_pend.
//   - Source IRQ or SWBRK with nmi_pend=1 (hijack): vector_addr<=VEC_NMI and clear nmi_pend.
//     b_flag keeps its value.
//   - After vector_fetch, vector_addr is frozen until the sequence exits.
//  An IRQ that deasserts between int_flag=1 and T1 is still serviced once it is committed to SERVICE.
//  When clk_ph1=0, all registers hold their values.
// TESTING
//  1. Release rst, run ph1 with next_cycle cycling -> int_flag=1 before the first T1.
//     SERVICE entered with suppress_write=1 and vector_addr=FFFC.
//     rst_pend clears at vector_fetch; no re-entry follows.
//  2. nmi_n 1->0 held low for 20 ph1 -> exactly one service with vector_addr=FFFA and b_flag=0.
//     nmi_pending=0 after vector_fetch.
//  3. irq_n=0 with i_flag=1 -> int_flag stays 0. Drop i_flag to 0 -> int_flag=1 on the next ph1.
//     Service uses vector FFFE with b_flag=0.
//  4. IR=00 software BRK, NMI edge before vector_fetch -> vector_addr=FFFA with b_flag=1.
//     nmi_pending is cleared.
//  5. NMI edge and irq_n=0 on the same ph1 -> NMI serviced first. The following instruction
//     executes, then the IRQ is serviced if i_flag=0.
//  6. rst pulsed mid-SERVICE (NMI) -> int_active=0 next edge, nmi_pend=0, rst_pend=1.
//     The RESET sequence follows.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: RESET/NMI/IRQ arbitration and BRK-sequence tracking for the 6502 core.
// Ports: sys_clock/rst/clk_ph1 timing; nmi_n, irq_n, i_flag sources; next_cycle, IR,
//   vector_fetch from the controller/datapath; int_flag, int_active, b_flag, suppress_write,
//   vector_addr, nmi_pending to the controller/datapath.
module interrupt_sequencer #(
    parameter logic [15:0] VEC_NMI   = 16'hFFFA,
    parameter logic [15:0] VEC_RESET = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ   = 16'hFFFE
) (
    input  logic        sys_clock,
    input  logic        rst,
    input  logic        clk_ph1,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic [2:0]  next_cycle,
    input  logic [7:0]  IR,
    input  logic        vector_fetch,
    output logic        int_flag,
    output logic        int_active,
    output logic        b_flag,
    output logic        suppress_write,
    output logic [15:0] vector_addr,
    output logic        nmi_pending
);

    typedef enum logic [1:0] {IDLE, SERVICE, SWBRK} state_t;
    typedef enum logic [1:0] {SRC_RESET, SRC_NMI, SRC_IRQ} src_t;

    state_t      state, state_d;
    src_t        src, src_d;
    logic        rst_pend, rst_pend_d;
    logic        nmi_pend, nmi_pend_d;
    logic        nmi_prev, nmi_prev_d;
    logic        int_flag_d, int_active_d, b_flag_d, suppress_d;
    logic [15:0] vector_d;
    // vec_done freezes vector_addr once the vector has been read
    logic        vec_done, vec_done_d;
    // post_svc blocks polling for one ph1 so the next instruction runs
    logic        post_svc, post_svc_d;
    logic        irq_req, nmi_edge, nmi_clr;

    assign nmi_pending = nmi_pend;

    always_comb begin
        state_d      = state;
        src_d        = src;
        rst_pend_d   = rst_pend;
        int_active_d = int_active;
        b_flag_d     = b_flag;
        suppress_d   = suppress_write;
        vector_d     = vector_addr;
        vec_done_d   = vec_done;
        post_svc_d   = 1'b0;
        nmi_clr      = 1'b0;
        irq_req      = ~irq_n & ~i_flag;
        nmi_edge     = nmi_prev & ~nmi_n;
        nmi_prev_d   = nmi_n;
        int_flag_d   = (state == IDLE) & ~post_svc
                     & (rst_pend | nmi_pend | irq_req);
        unique case (state)
            IDLE: begin
                if (next_cycle == 3'd1 && int_flag) begin
                    state_d      = SERVICE;
                    int_active_d = 1'b1;
                    b_flag_d     = 1'b0;
                    vec_done_d   = 1'b0;
                    // committed: a vanished IRQ still falls through to IRQ
                    if (rst_pend) begin
                        src_d      = SRC_RESET;
                        suppress_d = 1'b1;
                        vector_d   = VEC_RESET;
                    end else if (nmi_pend) begin
                        src_d    = SRC_NMI;
                        vector_d = VEC_NMI;
                    end else begin
                        src_d    = SRC_IRQ;
                        vector_d = VEC_IRQ;
                    end
                end else if (next_cycle == 3'd2 && IR == 8'h00
                             && !int_active) begin
                    state_d    = SWBRK;
                    src_d      = SRC_IRQ;
                    b_flag_d   = 1'b1;
                    vector_d   = VEC_IRQ;
                    vec_done_d = 1'b0;
                end
            end
            SERVICE, SWBRK: begin
                if (vector_fetch && !vec_done) begin
                    vec_done_d = 1'b1;
                    if (src == SRC_IRQ) begin
                        // NMI hijacks an IRQ/BRK that has not read its vector
                        if (nmi_pend) begin
                            vector_d = VEC_NMI;
                            nmi_clr  = 1'b1;
                        end
                    end else if (src == SRC_NMI) begin
                        nmi_clr = 1'b1;
                    end else begin
                        rst_pend_d = 1'b0;
                    end
                end
                if (next_cycle == 3'd1) begin
                    state_d      = IDLE;
                    int_active_d = 1'b0;
                    suppress_d   = 1'b0;
                    b_flag_d     = 1'b0;
                    vec_done_d   = 1'b0;
                    post_svc_d   = (state == SERVICE);
                end
            end
            default: state_d = IDLE;
        endcase
        // a new edge wins over a coincident clear
        nmi_pend_d = nmi_edge | (nmi_pend & ~nmi_clr);
    end

    always_ff @(posedge sys_clock) begin
        if (rst) begin
            state          <= IDLE;
            src            <= SRC_RESET;
            rst_pend       <= 1'b1;
            nmi_pend       <= 1'b0;
            nmi_prev       <= 1'b1;
            int_flag       <= 1'b0;
            int_active     <= 1'b0;
            b_flag         <= 1'b0;
            suppress_write <= 1'b0;
            vector_addr    <= VEC_RESET;
            vec_done       <= 1'b0;
            post_svc       <= 1'b0;
        end else if (clk_ph1) begin
            state          <= state_d;
            src            <= src_d;
            rst_pend       <= rst_pend_d;
            nmi_pend       <= nmi_pend_d;
            nmi_prev       <= nmi_prev_d;
            int_flag       <= int_flag_d;
            int_active     <= int_active_d;
            b_flag         <= b_flag_d;
            suppress_write <= suppress_d;
            vector_addr    <= vector_d;
            vec_done       <= vec_done_d;
            post_svc       <= post_svc_d;
        end
    end

endmodule
